// File: rtl/result_drain_pkg.sv
// Shared constants and FSM encoding for the output-memory drain path.
package result_drain_pkg;

    localparam int unsigned RESULT_W        = 23;
    localparam int unsigned OUT_ADDR_W      = 4;
    localparam int unsigned NUM_RESULTS_DEF = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } drain_state_t;

endpackage

// File: rtl/result_skid2.sv
// Two-entry FIFO holding prefetched result words; push and pop may coincide at any occupancy.
module result_skid2
    import result_drain_pkg::*;
#(
    parameter int unsigned W = RESULT_W + OUT_ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         head;
    logic         tail;
    logic         do_pop;

    assign do_pop    = pop && (occ != 2'd0);
    assign head_data = mem[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            occ    <= 2'd0;
        end else begin
            // When full, tail == head, so a simultaneous push reuses the slot being popped.
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ~tail;
            end
            if (do_pop) begin
                head <= ~head;
            end
            occ <= occ + 2'(push) - 2'(do_pop);
            assert (!(push && !do_pop && occ == 2'd2));
        end
    end

endmodule

// File: rtl/result_drain.sv
// Streams output-memory results 0..NUM_RESULTS-1 out on a valid/ready port with optional ReLU.
module result_drain
    import result_drain_pkg::*;
#(
    parameter int unsigned NUM_RESULTS = NUM_RESULTS_DEF,
    parameter int unsigned ADDR_W      = OUT_ADDR_W,
    parameter int unsigned DATA_W      = RESULT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              relu_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned ENT_W = DATA_W + ADDR_W;
    localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(NUM_RESULTS);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_RESULTS - 1);

    drain_state_t      state;
    logic              relu_q;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic              inflight;
    logic [ADDR_W-1:0] cap_addr;

    logic [1:0]        occ;
    logic [ENT_W-1:0]  head;
    logic              pop;
    logic [DATA_W-1:0] cap_word;
    logic [2:0]        pending;
    logic              can_issue;

    assign pop = out_valid && out_ready;

    // Reads on the address bus and in the capture stage both still claim a buffer slot.
    assign pending   = 3'(occ) + 3'(rd_en) + 3'(inflight);
    assign can_issue = (state == RUN) && (issue_cnt < TOTAL_CNT)
                     && (pending < (3'd2 + 3'(pop)));

    assign cap_word = (relu_q && rd_data[DATA_W-1]) ? '0 : rd_data;

    result_skid2 #(.W(ENT_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({cap_addr, cap_word}),
        .pop       (pop),
        .head_data (head),
        .occ       (occ)
    );

    assign out_valid           = (occ != 2'd0);
    assign {out_idx, out_data} = head;
    assign out_last            = out_valid && (out_idx == ADDR_W'(NUM_RESULTS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            relu_q    <= 1'b0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            inflight  <= 1'b0;
            cap_addr  <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            inflight <= rd_en;
            cap_addr <= rd_addr;
            rd_en    <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        relu_q    <= relu_en;
                        out_cnt   <= '0;
                        issue_cnt <= CNT_W'(1);
                        rd_en     <= 1'b1;
                        rd_addr   <= '0;
                    end
                end
                RUN: begin
                    if (can_issue) begin
                        rd_en     <= 1'b1;
                        rd_addr   <= ADDR_W'(issue_cnt);
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    end
                    if (pop) begin
                        out_cnt <= out_cnt + CNT_W'(1);
                        if (out_cnt == LAST_CNT) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
